ifetch: RTL and testbench

- Instruction fetch stage directly upstream of the decoder.
- Owns the PC and issues in-order requests to instruction memory.
- Buffers returned words in a small FIFO and presents one instruction per cycle on `ins`, which drives the decoder's `o` input.
- Stops fetching when the decoder flags HALT, drains in-flight fetches, then waits for `restart`.

---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_if.sv | 30 +++
 rtl/ifetch_fifo.sv | 51 +++++
 rtl/ifetch.sv | 92 +++++++++
 tb/tb_ifetch.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared state encodings, NOP word and parameter defaults for ifetch
package ifetch_pkg;

    typedef enum logic [1:0] {
        IF_RUN   = 2'd0,
        IF_DRAIN = 2'd1,
        IF_HALT  = 2'd2
    } if_state_e;

    localparam logic [15:0] NOP_INS = 16'h0000;

    localparam int IW_DEF       = 16;
    localparam int AW_DEF       = 8;
    localparam int RESET_PC_DEF = 0;
    localparam int DEPTH_DEF    = 2;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - instruction memory bus and decoder-side signals of the fetch stage
interface ifetch_if #(
    parameter int IW = ifetch_pkg::IW_DEF,
    parameter int AW = ifetch_pkg::AW_DEF
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;

    logic [IW-1:0] ins;
    logic [AW-1:0] ins_pc;
    logic          ins_valid;
    logic          ins_ready;
    logic          halt;
    logic          restart;
    logic          halted;

    modport master (
        output imem_req, imem_addr, ins, ins_pc, ins_valid, halted,
        input  imem_gnt, imem_rvalid, imem_rdata, ins_ready, halt, restart
    );

    modport slave (
        input  imem_req, imem_addr, ins, ins_pc, ins_valid, halted,
        output imem_gnt, imem_rvalid, imem_rdata, ins_ready, halt, restart
    );

endinterface

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - DEPTH x W synchronous FIFO with flush; push+pop allowed when full
module ifetch_fifo #(
    parameter int  DEPTH = 2,
    parameter int  W     = 24,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; consumers qualify head with count.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - fetch stage: owns the PC, issues credited in-order fetches, buffers words for the decoder
module ifetch
    import ifetch_pkg::*;
#(
    parameter int IW       = IW_DEF,
    parameter int AW       = AW_DEF,
    parameter int RESET_PC = RESET_PC_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);

    localparam int CW = cnt_w(DEPTH);

    if_state_e        state;
    if_state_e        state_n;
    logic [AW-1:0]    pc;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    out_n;
    logic [CW-1:0]    count;
    logic [AW+IW-1:0] head;
    logic [AW-1:0]    rsp_pc;
    logic             valid;
    logic             pop;
    logic             hacc;
    logic             credit_ok;
    logic             grant;
    logic             push;

    assign valid = (count != '0) && (state == IF_RUN);
    assign pop   = valid && bus.ins_ready && !bus.halt;
    assign hacc  = valid && bus.ins_ready && bus.halt;

    assign credit_ok = (int'(outstanding) + int'(count) - int'(pop)) < DEPTH;

    assign bus.imem_req  = !rst && (state == IF_RUN) && !hacc && credit_ok;
    assign bus.imem_addr = pc;
    assign grant         = bus.imem_req && bus.imem_gnt;

    // Responses return in order, so the oldest outstanding address sits
    // exactly 'outstanding' words behind the fetch PC.
    assign rsp_pc = pc - AW'(outstanding);

    assign push  = bus.imem_rvalid && (state == IF_RUN) && !hacc;
    assign out_n = outstanding + CW'(grant) - CW'(bus.imem_rvalid);

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + IW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (hacc),
        .wdata ({rsp_pc, bus.imem_rdata}),
        .head  (head),
        .count (count)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IF_RUN:   if (hacc) state_n = (out_n == '0) ? IF_HALT : IF_DRAIN;
            IF_DRAIN: if (out_n == '0) state_n = IF_HALT;
            IF_HALT:  if (bus.restart) state_n = IF_RUN;
            default:  state_n = IF_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IF_RUN;
            pc          <= AW'(RESET_PC);
            outstanding <= '0;
        end else begin
            assert (!(bus.imem_rvalid && outstanding == '0));
            state       <= state_n;
            outstanding <= out_n;
            if (state == IF_HALT && bus.restart) pc <= AW'(RESET_PC);
            else if (grant)                      pc <= pc + 1'b1;
        end
    end

    assign bus.ins_valid = valid;
    assign bus.ins       = valid ? head[IW-1:0] : IW'(NOP_INS);
    assign bus.ins_pc    = valid ? head[AW+IW-1:IW] : '0;
    assign bus.halted    = (state == IF_HALT);

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - randomized self-checking bench for ifetch against a queue-based reference model
module tb_ifetch;
    import ifetch_pkg::*;

    localparam int IW       = 16;
    localparam int AW       = 4;
    localparam int DEPTH    = 2;
    localparam int RESET_PC = 0;
    localparam int NPC      = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_if #(.IW(IW), .AW(AW)) bus ();

    ifetch #(.IW(IW), .AW(AW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [IW-1:0] mem [NPC];

    typedef enum {M_RUN, M_DRAIN, M_HALT} mmode_e;
    typedef struct {int pc; logic [IW-1:0] w;} ent_t;
    typedef struct {int addr; int due;} rsp_t;

    mmode_e mmode;
    int     m_pc;
    int     infl[$];
    ent_t   buff[$];
    int     next_pc;

    rsp_t rq[$];
    int   cyc = 0;
    int   last_due = 0;

    int            consumed_pc[$];
    logic [IW-1:0] consumed_w[$];
    int            grant_addr[$];
    int            first_grant_cyc = -1;
    int            first_valid_cyc = -1;

    int p_gnt = 100, dmin = 1, dmax = 1, p_ready = 100, p_halt = 0, p_restart = 0;
    bit halt_on_last = 1'b0;
    bit force_restart = 1'b0;
    bit rst_req = 1'b1;
    int rst_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mmode    = M_RUN;
        m_pc     = RESET_PC;
        next_pc  = RESET_PC;
        last_due = 0;
        infl.delete();
        buff.delete();
        rq.delete();
    endtask

    task automatic cycle();
        bit e_valid, e_req, pop, hacc, rv;
        int a, d;
        @(negedge clk);
        rst = rst_req;
        if (rst) begin
            bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
            bus.ins_ready = 0; bus.halt = 0; bus.restart = 0;
        end else begin
            bus.imem_gnt  = ($urandom_range(99) < p_gnt);
            bus.ins_ready = ($urandom_range(99) < p_ready);
            if (halt_on_last) bus.halt = (buff.size() > 0) && (buff[0].w == 16'h0001);
            else              bus.halt = ($urandom_range(99) < p_halt);
            bus.restart = force_restart || ($urandom_range(99) < p_restart);
            rv = (rq.size() > 0) && (rq[0].due <= cyc);
            bus.imem_rvalid = rv;
            bus.imem_rdata  = rv ? mem[rq[0].addr] : IW'($urandom);
        end
        #1;
        if (rst) begin
            if (rst_cycles > 0) begin
                chk("rst_imem_req", bus.imem_req, 0);
                chk("rst_ins_valid", bus.ins_valid, 0);
                chk("rst_ins", bus.ins, 0);
                chk("rst_ins_pc", bus.ins_pc, 0);
                chk("rst_halted", bus.halted, 0);
                chk("rst_imem_addr", bus.imem_addr, RESET_PC);
            end
            rst_cycles++;
            model_reset();
        end else begin
            rst_cycles = 0;
            e_valid = (mmode == M_RUN) && (buff.size() > 0);
            pop     = e_valid && bus.ins_ready && !bus.halt;
            hacc    = e_valid && bus.ins_ready && bus.halt;
            e_req   = (mmode == M_RUN) && !hacc && (infl.size() + buff.size() - int'(pop) < DEPTH);

            chk("ins_valid", bus.ins_valid, e_valid);
            chk("ins", bus.ins, e_valid ? buff[0].w : 16'h0000);
            chk("ins_pc", bus.ins_pc, e_valid ? buff[0].pc : 0);
            chk("halted", bus.halted, mmode == M_HALT);
            chk("imem_req", bus.imem_req, e_req);
            chk("imem_addr", bus.imem_addr, m_pc);

            if (first_valid_cyc < 0 && bus.ins_valid) first_valid_cyc = cyc;
            if (pop || hacc) begin
                chk("order_pc", bus.ins_pc, next_pc);
                consumed_pc.push_back(int'(bus.ins_pc));
                consumed_w.push_back(bus.ins);
                next_pc = (next_pc + 1) % NPC;
            end

            if (pop) void'(buff.pop_front());
            if (rv) begin
                a = (infl.size() > 0) ? infl.pop_front() : 0;
                if (mmode == M_RUN && !hacc) buff.push_back('{a, mem[a]});
            end
            if (hacc) buff.delete();
            if (e_req && bus.imem_gnt) begin
                infl.push_back(m_pc);
                m_pc = (m_pc + 1) % NPC;
            end
            case (mmode)
                M_RUN:   if (hacc) mmode = (infl.size() == 0) ? M_HALT : M_DRAIN;
                M_DRAIN: if (infl.size() == 0) mmode = M_HALT;
                M_HALT:  if (bus.restart) begin
                    mmode = M_RUN; m_pc = RESET_PC; next_pc = RESET_PC;
                end
                default: mmode = M_RUN;
            endcase

            if (rv) void'(rq.pop_front());
            if (bus.imem_req && bus.imem_gnt) begin
                d = cyc + $urandom_range(dmax, dmin);
                if (d < last_due) d = last_due;
                last_due = d;
                rq.push_back('{int'(bus.imem_addr), d});
                grant_addr.push_back(int'(bus.imem_addr));
                if (first_grant_cyc < 0) first_grant_cyc = cyc;
            end
        end
        cyc++;
    endtask

    initial begin
        int g0;
        mem[0] = 16'h2005; mem[1] = 16'h2103; mem[2] = 16'h1200; mem[3] = 16'h0001;
        for (int i = 4; i < NPC; i++) mem[i] = IW'($urandom) | 16'h8000;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
        bus.ins_ready = 0; bus.halt = 0; bus.restart = 0;
        model_reset();

        rst_req = 1; repeat (3) cycle();
        rst_req = 0;

        // Cold start: halt taken on the 0x0001 word at pc3.
        halt_on_last = 1;
        repeat (14) cycle();
        halt_on_last = 0;
        if (grant_addr.size() < 4 || consumed_w.size() < 4) begin
            n_cmp++; n_bad++;
            $display("FAIL cold_start: %0d grants / %0d consumed, required 4 / 4", grant_addr.size(), consumed_w.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                chk("cold_addr", grant_addr[i], i);
                chk("cold_pc", consumed_pc[i], i);
            end
            chk("cold_w0", consumed_w[0], 16'h2005);
            chk("cold_w1", consumed_w[1], 16'h2103);
            chk("cold_w2", consumed_w[2], 16'h1200);
            chk("cold_w3", consumed_w[3], 16'h0001);
        end
        chk("cold_latency", first_valid_cyc - first_grant_cyc, 2);
        chk("cold_halted", bus.halted, 1);
        chk("cold_no_req", bus.imem_req, 0);

        // Restart, then backpressure from the first valid word.
        g0 = grant_addr.size();
        force_restart = 1; cycle(); force_restart = 0;
        p_ready = 0;
        cycle();
        chk("restart_addr", bus.imem_addr, RESET_PC);
        chk("restart_req", bus.imem_req, 1);
        repeat (8) cycle();
        chk("bp_ins", bus.ins, 16'h2005);
        chk("bp_pc", bus.ins_pc, 0);
        chk("bp_valid", bus.ins_valid, 1);
        chk("bp_grants", grant_addr.size() - g0, DEPTH);
        p_ready = 100;
        repeat (12) cycle();

        // Random traffic with a mid-stream reset; AW=4 makes PC wrap often.
        p_gnt = 70; dmin = 1; dmax = 4; p_ready = 75; p_halt = 3; p_restart = 10;
        repeat (1500) cycle();
        rst_req = 1; repeat (2) cycle(); rst_req = 0;
        repeat (1500) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
